mem_arbiter: RTL and testbench

Two-master arbiter sharing one wait-state memory bus (ROM/RAM with `needWait`-style handshake) between instruction fetch (master 0) and data access (master 1). Each master sees a private, non-tristated copy of the bus protocol. Requests are granted round-robin, one transaction at a time. A one-cycle strobe-low release follows every completed transaction so the slave's completion flag rearms.

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one wait-state memory bus between two masters
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_re_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_wait_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_re_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_wait_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  inout  wire  [DATA_W-1:0] mem_data_io,
  input  logic              mem_wait_i
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

  state_t            state;
  logic              last;
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] wdata;

  assign req0 = m0_re_i | m0_we_i;
  assign req1 = m1_re_i | m1_we_i;

  // last==1 after reset, so master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (req0 && (!req1 || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
          end else if (req1) begin
            state <= GRANT1;
            last  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT0: if (!req0 || !mem_wait_i) state <= RELEASE;
        GRANT1: if (!req1 || !mem_wait_i) state <= RELEASE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes depend only on state and master inputs, never on mem_wait_i
  always_comb begin
    mem_addr_o = '0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    wdata      = '0;
    case (state)
      GRANT0: begin
        mem_addr_o = m0_addr_i;
        mem_we_o   = m0_we_i;
        mem_re_o   = m0_re_i & ~m0_we_i;
        wdata      = m0_data_i;
      end
      GRANT1: begin
        mem_addr_o = m1_addr_i;
        mem_we_o   = m1_we_i;
        mem_re_o   = m1_re_i & ~m1_we_i;
        wdata      = m1_data_i;
      end
      default: ;
    endcase
  end

  assign mem_data_io = mem_we_o ? wdata : {DATA_W{1'bz}};

  assign m0_wait_o = req0 & ~((state == GRANT0) & ~mem_wait_i);
  assign m1_wait_o = req1 & ~((state == GRANT1) & ~mem_wait_i);

  assign m0_data_o = ((state == GRANT0) && m0_re_i && !m0_we_i) ? mem_data_io : '0;
  assign m1_data_o = ((state == GRANT1) && m1_re_i && !m1_we_i) ? mem_data_io : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a 1-cycle-latency memory model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_re, m0_we, m1_re, m1_we;
  wire  [15:0] m0_rdata, m1_rdata;
  wire         m0_wait, m1_wait;
  wire  [15:0] mem_addr;
  wire         mem_re, mem_we, mem_wait;
  wire  [15:0] mem_data;
  logic [15:0] mem [0:255];
  logic        done = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_addr_i(m0_addr), .m0_re_i(m0_re), .m0_we_i(m0_we), .m0_data_i(m0_wdata),
    .m0_data_o(m0_rdata), .m0_wait_o(m0_wait),
    .m1_addr_i(m1_addr), .m1_re_i(m1_re), .m1_we_i(m1_we), .m1_data_i(m1_wdata),
    .m1_data_o(m1_rdata), .m1_wait_o(m1_wait),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_data_io(mem_data), .mem_wait_i(mem_wait)
  );

  // Slave: stalls the first strobed cycle; parks 0x1234 on the bus when the arbiter should not drive
  assign mem_wait = (mem_re | mem_we) & ~done;
  assign mem_data = mem_we ? 16'hzzzz : (mem_re ? mem[mem_addr[8:1]] : 16'h1234);

  always @(posedge clk) begin
    done <= mem_re | mem_we;
    if (mem_we && !mem_wait) mem[mem_addr[8:1]] <= mem_data;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    m0_addr = '0; m0_wdata = '0; m0_re = 1'b0; m0_we = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_re = 1'b0; m1_we = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    m0_re = 1'b1;
    next_cycle();
    sample();
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL reset_mem_re got %0h exp 0", mem_re); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %0h exp 0", mem_we); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
    tests++; if (mem_data !== 16'h1234) begin fails++; $display("FAIL reset_bus_released got %h exp 1234", mem_data); end
    tests++; if (m0_rdata !== 16'h0000) begin fails++; $display("FAIL reset_m0_data got %h exp 0000", m0_rdata); end
    tests++; if (m1_rdata !== 16'h0000) begin fails++; $display("FAIL reset_m1_data got %h exp 0000", m1_rdata); end
    tests++; if (m0_wait !== 1'b1) begin fails++; $display("FAIL reset_m0_wait got %0h exp 1", m0_wait); end
    tests++; if (m1_wait !== 1'b0) begin fails++; $display("FAIL reset_m1_wait got %0h exp 0", m1_wait); end
    next_cycle();
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    do_reset();
    m0_addr = 16'h0000; m0_re = 1'b1;
    sample();
    tests++; if (m0_wait !== 1'b1) begin fails++; $display("FAIL single_c0_wait got %0h exp 1", m0_wait); end
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL single_c0_mem_re got %0h exp 0", mem_re); end
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b1) begin fails++; $display("FAIL single_c1_mem_re got %0h exp 1", mem_re); end
    tests++; if (m0_wait !== 1'b1) begin fails++; $display("FAIL single_c1_wait got %0h exp 1", m0_wait); end
    next_cycle(); sample();
    tests++; if (m0_wait !== 1'b0) begin fails++; $display("FAIL single_c2_wait got %0h exp 0", m0_wait); end
    tests++; if (m0_rdata !== 16'h0bb6) begin fails++; $display("FAIL single_c2_data got %h exp 0bb6", m0_rdata); end
    next_cycle();
    m0_re = 1'b0;
    sample();
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL single_c3_mem_re got %0h exp 0", mem_re); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL single_c3_addr got %h exp 0000", mem_addr); end
    tests++; if (m0_rdata !== 16'h0000) begin fails++; $display("FAIL single_c3_data got %h exp 0000", m0_rdata); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    m0_addr = 16'h0002; m0_re = 1'b1;
    m1_addr = 16'h0100; m1_re = 1'b1;
    sample();
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL simul_c0_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (mem_addr !== 16'h0002 || mem_re !== 1'b1) begin fails++; $display("FAIL simul_c1_grant0 got addr %h re %0h exp 0002 1", mem_addr, mem_re); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL simul_c1_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (m0_wait !== 1'b0) begin fails++; $display("FAIL simul_c2_m0_wait got %0h exp 0", m0_wait); end
    tests++; if (m0_rdata !== 16'h0102) begin fails++; $display("FAIL simul_c2_m0_data got %h exp 0102", m0_rdata); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL simul_c2_m1_wait got %0h exp 1", m1_wait); end
    next_cycle();
    m0_re = 1'b0;
    sample();
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL simul_c3_release got %0h exp 0", mem_re); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL simul_c3_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (mem_addr !== 16'h0100 || mem_re !== 1'b1) begin fails++; $display("FAIL simul_c4_grant1 got addr %h re %0h exp 0100 1", mem_addr, mem_re); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL simul_c4_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (m1_wait !== 1'b0) begin fails++; $display("FAIL simul_c5_m1_wait got %0h exp 0", m1_wait); end
    tests++; if (m1_rdata !== 16'h1001) begin fails++; $display("FAIL simul_c5_m1_data got %h exp 1001", m1_rdata); end
    next_cycle();
    m1_re = 1'b0;
  endtask

  task automatic test_round_robin;
    int exp_code [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
    int code;
    do_reset();
    m0_addr = 16'h0000; m0_re = 1'b1;
    m1_addr = 16'h0100; m1_re = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_cycle(); sample();
      if (!mem_re) code = 0;
      else if (mem_addr == 16'h0000) code = 1;
      else if (mem_addr == 16'h0100) code = 2;
      else code = 3;
      tests++; if (code !== exp_code[i]) begin fails++; $display("FAIL rr_cycle%0d got %0d exp %0d", i + 1, code, exp_code[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_write_collision;
    do_reset();
    m1_addr = 16'h0004; m1_we = 1'b1; m1_re = 1'b1; m1_wdata = 16'hA5A5;
    next_cycle(); sample();
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL wr_c1_mem_we got %0h exp 1", mem_we); end
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL wr_c1_mem_re got %0h exp 0", mem_re); end
    tests++; if (mem_addr !== 16'h0004) begin fails++; $display("FAIL wr_c1_addr got %h exp 0004", mem_addr); end
    tests++; if (mem_data !== 16'hA5A5) begin fails++; $display("FAIL wr_c1_bus got %h exp a5a5", mem_data); end
    tests++; if (m1_rdata !== 16'h0000) begin fails++; $display("FAIL wr_c1_m1_data got %h exp 0000", m1_rdata); end
    next_cycle(); sample();
    tests++; if (m1_wait !== 1'b0) begin fails++; $display("FAIL wr_c2_m1_wait got %0h exp 0", m1_wait); end
    next_cycle();
    m1_we = 1'b0; m1_re = 1'b0;
    sample();
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL wr_c3_mem_we got %0h exp 0", mem_we); end
    tests++; if (mem_data !== 16'h1234) begin fails++; $display("FAIL wr_c3_bus_released got %h exp 1234", mem_data); end
    tests++; if (mem[2] !== 16'hA5A5) begin fails++; $display("FAIL wr_stored got %h exp a5a5", mem[2]); end
  endtask

  task automatic test_abort;
    do_reset();
    m0_addr = 16'h0000; m0_re = 1'b1;
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b1 || m0_wait !== 1'b1) begin fails++; $display("FAIL abort_c1 got re %0h wait %0h exp 1 1", mem_re, m0_wait); end
    next_cycle();
    m0_re = 1'b0;
    m1_addr = 16'h0100; m1_re = 1'b1;
    sample();
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL abort_c2_mem_re got %0h exp 0", mem_re); end
    tests++; if (m0_rdata !== 16'h0000) begin fails++; $display("FAIL abort_c2_m0_data got %h exp 0000", m0_rdata); end
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b0 || mem_addr !== 16'h0000) begin fails++; $display("FAIL abort_c3_release got re %0h addr %h exp 0 0000", mem_re, mem_addr); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL abort_c3_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h0100) begin fails++; $display("FAIL abort_c4_grant1 got re %0h addr %h exp 1 0100", mem_re, mem_addr); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    m1_addr = 16'h0100; m1_re = 1'b1;
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b1 || mem_wait !== 1'b1) begin fails++; $display("FAIL rstmid_c1 got re %0h wait %0h exp 1 1", mem_re, mem_wait); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_addr = 16'h0002; m0_re = 1'b1;
    sample();
    tests++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_c2_strobes got re %0h we %0h exp 0 0", mem_re, mem_we); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL rstmid_c2_addr got %h exp 0000", mem_addr); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL rstmid_c2_m1_wait got %0h exp 1", m1_wait); end
    next_cycle(); sample();
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h0002) begin fails++; $display("FAIL rstmid_c3_tie_m0 got re %0h addr %h exp 1 0002", mem_re, mem_addr); end
    tests++; if (m1_wait !== 1'b1) begin fails++; $display("FAIL rstmid_c3_m1_wait got %0h exp 1", m1_wait); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h0bb6;
    mem[1]    = 16'h0102;
    mem[8'h80] = 16'h1001;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_write_collision();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
